// File: rtl/elevator_pkg.sv
// Shared types and direction codes for the SCAN elevator controller.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      MOVE_UP   = 2'b01,
      MOVE_DOWN = 2'b10,
      DOOR_OPEN = 2'b11
   } state_t;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-call register with set/clear and above/below/here reduction
// relative to the current floor (live calls count as well as latched ones).
module elevator_req_reg
   import elevator_pkg::*;
#(
   parameter int  NUM_FLOORS = 3,
   localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NUM_FLOORS-1:0] req_i,
   input  logic [NUM_FLOORS-1:0] clr_i,
   input  logic [FLOOR_W-1:0]    floor_i,
   output logic [NUM_FLOORS-1:0] pending_o,
   output logic [NUM_FLOORS-1:0] req_mask_o,
   output logic                  req_above_o,
   output logic                  req_below_o,
   output logic                  req_here_o
);

   logic [NUM_FLOORS-1:0] pending_q;
   logic [NUM_FLOORS-1:0] pending_d;
   logic [NUM_FLOORS-1:0] mask_s;

   // Latch new calls; a clear for the same floor wins.
   always_comb begin
      pending_d = (pending_q | req_i) & ~clr_i;
   end

   // Pending register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= {NUM_FLOORS{1'b0}};
      end else begin
         pending_q <= pending_d;
      end
   end

   // Classify every call relative to the car position.
   always_comb begin
      mask_s      = pending_q | req_i;
      req_above_o = 1'b0;
      req_below_o = 1'b0;
      req_here_o  = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) > floor_i) begin
            req_above_o = req_above_o | mask_s[i];
         end else if (FLOOR_W'(i) < floor_i) begin
            req_below_o = req_below_o | mask_s[i];
         end else begin
            req_here_o = mask_s[i];
         end
      end
   end

   assign pending_o  = pending_q;
   assign req_mask_o = mask_s;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller serving latched calls with a SCAN policy,
// internal door dwell timer and shaft-sensor driven floor counter.
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int  NUM_FLOORS  = 3,
   parameter int  DOOR_CYCLES = 8,
   localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] floor_req,
   input  logic                  elevator_arrived,
   input  logic                  door_hold,
   output logic [NUM_FLOORS-1:0] floor_led,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic [1:0]            elevator_direction,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int                    TMR_W      = $clog2(DOOR_CYCLES + 1);
   localparam logic [TMR_W-1:0]      DOOR_LOAD  = TMR_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0]    TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [FLOOR_W-1:0]    BOT_FLOOR  = {FLOOR_W{1'b0}};
   localparam logic [NUM_FLOORS-1:0] FLOOR_ONE  = NUM_FLOORS'(1);

   state_t                state_q, state_d;
   logic [FLOOR_W-1:0]    floor_q, floor_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic                  last_up_q, last_up_d;
   logic [NUM_FLOORS-1:0] clr_s;
   logic [NUM_FLOORS-1:0] req_mask_s;
   logic                  req_above_s, req_below_s, req_here_s;
   logic [FLOOR_W-1:0]    floor_up_s, floor_dn_s;

   elevator_req_reg #(
      .NUM_FLOORS (NUM_FLOORS)
   ) u_req_reg (
      .clk_i       (clk),
      .rst_ni      (rst),
      .req_i       (floor_req),
      .clr_i       (clr_s),
      .floor_i     (floor_q),
      .pending_o   (pending),
      .req_mask_o  (req_mask_s),
      .req_above_o (req_above_s),
      .req_below_o (req_below_s),
      .req_here_o  (req_here_s)
   );

   assign floor_up_s = floor_q + FLOOR_W'(1);
   assign floor_dn_s = floor_q - FLOOR_W'(1);

   // State, floor counter, dwell timer and sweep memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         floor_q   <= BOT_FLOOR;
         timer_q   <= {TMR_W{1'b0}};
         last_up_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         timer_q   <= timer_d;
         last_up_q <= last_up_d;
      end
   end

   // SCAN decisions; a stop clears its call on the same edge it is taken.
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      timer_d   = timer_q;
      last_up_d = last_up_q;
      clr_s     = {NUM_FLOORS{1'b0}};
      case (state_q)
         IDLE: begin
            if (req_here_s) begin
               state_d = DOOR_OPEN;
               timer_d = DOOR_LOAD;
               clr_s   = FLOOR_ONE << floor_q;
            end else if (req_above_s && req_below_s) begin
               state_d = last_up_q ? MOVE_UP : MOVE_DOWN;
            end else if (req_above_s) begin
               state_d   = MOVE_UP;
               last_up_d = 1'b1;
            end else if (req_below_s) begin
               state_d   = MOVE_DOWN;
               last_up_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         MOVE_UP: begin
            last_up_d = 1'b1;
            if (elevator_arrived && (floor_q != TOP_FLOOR)) begin
               floor_d = floor_up_s;
               if (req_mask_s[floor_up_s]) begin
                  state_d = DOOR_OPEN;
                  timer_d = DOOR_LOAD;
                  clr_s   = FLOOR_ONE << floor_up_s;
               end else begin
                  state_d = MOVE_UP;
               end
            end else begin
               state_d = MOVE_UP;
            end
         end
         MOVE_DOWN: begin
            last_up_d = 1'b0;
            if (elevator_arrived && (floor_q != BOT_FLOOR)) begin
               floor_d = floor_dn_s;
               if (req_mask_s[floor_dn_s]) begin
                  state_d = DOOR_OPEN;
                  timer_d = DOOR_LOAD;
                  clr_s   = FLOOR_ONE << floor_dn_s;
               end else begin
                  state_d = MOVE_DOWN;
               end
            end else begin
               state_d = MOVE_DOWN;
            end
         end
         DOOR_OPEN: begin
            // A call for the open floor only extends the dwell.
            clr_s = FLOOR_ONE << floor_q;
            if (door_hold || req_here_s) begin
               timer_d = DOOR_LOAD;
            end else if (timer_q != {TMR_W{1'b0}}) begin
               timer_d = timer_q - TMR_W'(1);
            end else if (last_up_q ? req_above_s : req_below_s) begin
               state_d = last_up_q ? MOVE_UP : MOVE_DOWN;
            end else if (last_up_q ? req_below_s : req_above_s) begin
               state_d   = last_up_q ? MOVE_DOWN : MOVE_UP;
               last_up_d = ~last_up_q;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore output decode.
   always_comb begin
      floor_led          = FLOOR_ONE << floor_q;
      cur_floor          = floor_q;
      door_open          = 1'b0;
      elevator_direction = DIR_IDLE;
      case (state_q)
         MOVE_UP:   elevator_direction = DIR_UP;
         MOVE_DOWN: elevator_direction = DIR_DOWN;
         DOOR_OPEN: door_open = 1'b1;
         IDLE:      elevator_direction = DIR_IDLE;
         default:   elevator_direction = DIR_IDLE;
      endcase
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench: a SCAN reference model predicts each stop (floor, dwell);
// a monitor pops and compares whenever the door opens and closes.
module tb_elevator_scan_ctrl;

   localparam int NF = 4;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NF-1:0] floor_req = '0;
   logic          elevator_arrived = 1'b0;
   logic          door_hold = 1'b0;
   logic [NF-1:0] floor_led;
   logic [1:0]    cur_floor;
   logic [1:0]    elevator_direction;
   logic          door_open;
   logic [NF-1:0] pending;

   typedef struct {
      int floor;
      int dwell;
   } stop_t;

   stop_t sb_q[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    model_floor = 0;
   bit    model_up = 1'b1;

   elevator_scan_ctrl #(
      .NUM_FLOORS  (NF),
      .DOOR_CYCLES (DC)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .floor_req          (floor_req),
      .elevator_arrived   (elevator_arrived),
      .door_hold          (door_hold),
      .floor_led          (floor_led),
      .cur_floor          (cur_floor),
      .elevator_direction (elevator_direction),
      .door_open          (door_open),
      .pending            (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void push(input int f, input int d);
      stop_t s;
      s.floor = f;
      s.dwell = d;
      sb_q.push_back(s);
   endfunction

   // SCAN reference: stop here first, sweep the preferred way, then the other.
   task automatic plan_batch(input logic [NF-1:0] m);
      bit above, below, go_up;
      int lo, hi;
      above = 1'b0; below = 1'b0; lo = -1; hi = -1;
      if (m[model_floor]) push(model_floor, DC);
      for (int i = 0; i < NF; i++) begin
         if (m[i] && i > model_floor) begin above = 1'b1; hi = i; end
         if (m[i] && i < model_floor && lo < 0) begin below = 1'b1; lo = i; end
      end
      go_up = model_up ? (above || !below) : (above && !below);
      if (go_up) begin
         for (int i = model_floor + 1; i < NF; i++) if (m[i]) push(i, DC);
         for (int i = model_floor - 1; i >= 0; i--) if (m[i]) push(i, DC);
         if (below) begin model_floor = lo; model_up = 1'b0; end
         else if (above) begin model_floor = hi; model_up = 1'b1; end
      end else begin
         for (int i = model_floor - 1; i >= 0; i--) if (m[i]) push(i, DC);
         for (int i = model_floor + 1; i < NF; i++) if (m[i]) push(i, DC);
         if (above) begin model_floor = hi; model_up = 1'b1; end
         else if (below) begin model_floor = lo; model_up = 1'b0; end
      end
   endtask

   task automatic drive_req(input logic [NF-1:0] m);
      floor_req = m;
      @(negedge clk);
      floor_req = '0;
   endtask

   task automatic pulse_arrived();
      elevator_arrived = 1'b1;
      @(negedge clk);
      elevator_arrived = 1'b0;
   endtask

   task automatic wait_door_open();
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (door_open) seen = 1'b1;
         else @(negedge clk);
      end
      chk("wait_door_open_timeout", 32'(seen), 32'd1);
   endtask

   // Acts as the shaft: pulses arrivals while moving, stray ones while the door is open.
   task automatic run_until_idle();
      bit done;
      int gap;
      done = 1'b0;
      gap  = int'($urandom_range(2, 0));
      for (int c = 0; c < 600 && !done; c++) begin
         if (elevator_direction == 2'b00 && !door_open && pending == '0) begin
            done = 1'b1;
            elevator_arrived = 1'b0;
         end else begin
            elevator_arrived = 1'b0;
            if (elevator_direction != 2'b00) begin
               if (gap == 0) begin
                  elevator_arrived = 1'b1;
                  gap = int'($urandom_range(2, 0));
               end else begin
                  gap--;
               end
            end else if (door_open && $urandom_range(7, 0) == 0) begin
               elevator_arrived = 1'b1;
            end
            @(negedge clk);
         end
      end
      elevator_arrived = 1'b0;
      chk("idle_timeout", 32'(done), 32'd1);
   endtask

   // Scoreboard monitor.
   initial begin
      bit    prev_door;
      bit    have_exp;
      int    open_cnt;
      stop_t e;
      prev_door = 1'b0; have_exp = 1'b0; open_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_door = 1'b0; have_exp = 1'b0; open_cnt = 0;
         end else begin
            if (door_open) begin
               if (!prev_door) begin
                  if (sb_q.size() == 0) begin
                     chk("unexpected_stop_floor", 32'(cur_floor), 32'hFFFF_FFFF);
                     have_exp = 1'b0;
                  end else begin
                     e = sb_q.pop_front();
                     have_exp = 1'b1;
                     chk("stop_floor", 32'(cur_floor), 32'(e.floor));
                     chk("stop_led", 32'(floor_led), 32'd1 << e.floor);
                     chk("stop_dir", 32'(elevator_direction), 32'd0);
                  end
                  open_cnt = 0;
               end
               open_cnt++;
            end else if (prev_door) begin
               if (have_exp) chk("dwell", 32'(open_cnt), 32'(e.dwell));
               have_exp = 1'b0;
            end
            prev_door = door_open;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NF-1:0] m;
      repeat (3) @(negedge clk);
      chk("rst_floor", 32'(cur_floor), 32'd0);
      chk("rst_led", 32'(floor_led), 32'b0001);
      chk("rst_dir", 32'(elevator_direction), 32'd0);
      chk("rst_door", 32'(door_open), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Call at the current floor.
      push(0, DC);
      drive_req(4'b0001);
      chk("here_door", 32'(door_open), 32'd1);
      run_until_idle();
      chk("here_floor", 32'(cur_floor), 32'd0);
      chk("here_pending", 32'(pending), 32'd0);

      // Two floors up with a pass-through at floor 1.
      push(2, DC);
      drive_req(4'b0100);
      chk("up_dir", 32'(elevator_direction), 32'b01);
      pulse_arrived();
      chk("pass_floor", 32'(cur_floor), 32'd1);
      chk("pass_door", 32'(door_open), 32'd0);
      pulse_arrived();
      run_until_idle();
      chk("up_final_floor", 32'(cur_floor), 32'd2);

      // Call below a passed floor is served on the return sweep.
      push(1, DC);
      drive_req(4'b0010);
      chk("down_dir", 32'(elevator_direction), 32'b10);
      run_until_idle();
      push(3, DC);
      push(0, DC);
      drive_req(4'b1000);
      pulse_arrived();
      chk("sweep_floor2", 32'(cur_floor), 32'd2);
      drive_req(4'b0001);
      chk("sweep_pending", 32'(pending), 32'b1001);
      pulse_arrived();
      run_until_idle();
      chk("sweep_final_floor", 32'(cur_floor), 32'd0);
      chk("sweep_pending_end", 32'(pending), 32'd0);

      // Door hold for 6 cycles, then a same-floor call in cycle 9: 9 + DC open cycles.
      push(2, 9 + DC);
      drive_req(4'b0100);
      pulse_arrived();
      pulse_arrived();
      wait_door_open();
      door_hold = 1'b1;
      repeat (6) @(negedge clk);
      door_hold = 1'b0;
      repeat (2) @(negedge clk);
      drive_req(4'b0100);
      chk("hold_pending", 32'(pending), 32'd0);
      chk("hold_door", 32'(door_open), 32'd1);
      run_until_idle();

      // Top-floor bound: stray arrivals with door open and idle are ignored.
      push(3, DC);
      drive_req(4'b1000);
      pulse_arrived();
      pulse_arrived();
      chk("top_door_floor", 32'(cur_floor), 32'd3);
      chk("top_door_open", 32'(door_open), 32'd1);
      run_until_idle();
      pulse_arrived();
      chk("top_idle_floor", 32'(cur_floor), 32'd3);
      chk("top_idle_known", 32'($isunknown(cur_floor)), 32'd0);
      chk("top_idle_led", 32'(floor_led), 32'b1000);
      chk("top_idle_dir", 32'(elevator_direction), 32'd0);

      // Randomised batches against the SCAN model.
      model_floor = 3;
      model_up    = 1'b1;
      for (int s = 0; s < 25; s++) begin
         m = NF'($urandom_range(15, 1));
         plan_batch(m);
         drive_req(m);
         run_until_idle();
         chk("rand_floor", 32'(cur_floor), 32'(model_floor));
         chk("rand_pending", 32'(pending), 32'd0);
         chk("rand_sb_empty", 32'(sb_q.size()), 32'd0);
      end

      // Asynchronous reset while moving up at floor 2 with calls pending.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      drive_req(4'b1000);
      pulse_arrived();
      pulse_arrived();
      drive_req(4'b0001);
      chk("pre_rst_floor", 32'(cur_floor), 32'd2);
      chk("pre_rst_dir", 32'(elevator_direction), 32'b01);
      chk("pre_rst_pending", 32'(pending), 32'b1001);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_floor", 32'(cur_floor), 32'd0);
      chk("mid_rst_led", 32'(floor_led), 32'b0001);
      chk("mid_rst_dir", 32'(elevator_direction), 32'd0);
      chk("mid_rst_door", 32'(door_open), 32'd0);
      chk("mid_rst_pending", 32'(pending), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
